// File: rtl/mnist_accel_pkg.sv
// Shared constants and types for the MNIST accelerator front end.
// The optional PIXEL_SUM_EN macro only affects image_frame_loader; nothing here depends on it.
package mnist_accel_pkg;
   localparam int IMG_DIM    = 14;
   localparam int CHUNK_W    = 7;
   localparam int NUM_CHUNKS = 28;
   localparam int IMG_BITS   = CHUNK_W * NUM_CHUNKS;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_LOAD  = 2'd1,
      LD_READY = 2'd2
   } loader_state_t;
endpackage

// File: rtl/chunk_popcount.sv
// Combinational count of set pixels in one chunk.
module chunk_popcount
   import mnist_accel_pkg::*;
#(
   parameter int W = CHUNK_W
) (
   input  logic [W-1:0] i_chunk,
   output logic [2:0]   o_count
);
   always_comb begin
      o_count = '0;
      for (int i = 0; i < W; i++) o_count = o_count + {2'b00, i_chunk[i]};
   end
endmodule

// File: rtl/image_frame_loader.sv
// Assembles a 196-bit binary image from 28 seven-pixel chunks and hands it over with ready/ack.
// Define PIXEL_SUM_EN to keep a running count of set pixels in pixel_sum.
module image_frame_loader
   import mnist_accel_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_en,
   input  logic                chunk_valid,
   input  logic [CHUNK_W-1:0]  chunk_in,
   input  logic                image_ack,
   output logic [IMG_BITS-1:0] image_data,
   output logic                image_ready,
   output logic                busy,
   output logic [4:0]          chunk_idx,
   output logic                overrun,
   output logic [7:0]          pixel_sum
);
   loader_state_t       r_state, w_state_nxt;
   logic                r_load_en_q;
   logic [IMG_BITS-1:0] r_image_data;
   logic [4:0]          r_chunk_idx;
   logic                r_overrun;
   logic                w_rise, w_start, w_abort, w_accept, w_last;

   assign w_rise   = load_en & ~r_load_en_q;
   assign w_last   = (r_chunk_idx == 5'(NUM_CHUNKS - 1));
   assign w_start  = (r_state == LD_IDLE) & w_rise;
   assign w_abort  = (r_state == LD_LOAD) & ~load_en;
   assign w_accept = (r_state == LD_LOAD) & load_en & chunk_valid;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         LD_IDLE:  if (w_rise) w_state_nxt = LD_LOAD;
         LD_LOAD: begin
            if (!load_en)                w_state_nxt = LD_IDLE;
            else if (chunk_valid && w_last) w_state_nxt = LD_READY;
         end
         LD_READY: if (image_ack || !load_en) w_state_nxt = LD_IDLE;
         default:  w_state_nxt = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LD_IDLE;
         r_load_en_q <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_load_en_q <= load_en;
      end
   end

   // Index holds at the last slot so it never wraps past 27.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_image_data <= '0;
         r_chunk_idx  <= '0;
      end else if (w_start || w_abort) begin
         r_image_data <= '0;
         r_chunk_idx  <= '0;
      end else if (w_accept) begin
         r_image_data[int'(r_chunk_idx)*CHUNK_W +: CHUNK_W] <= chunk_in;
         if (!w_last) r_chunk_idx <= r_chunk_idx + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    r_overrun <= 1'b0;
      else if (w_start)                              r_overrun <= 1'b0;
      else if ((r_state == LD_READY) && chunk_valid) r_overrun <= 1'b1;
   end

`ifdef PIXEL_SUM_EN
   logic [2:0] w_pop;
   logic [7:0] r_pixel_sum;

   chunk_popcount #(.W(CHUNK_W)) u_popcount (
      .i_chunk (chunk_in),
      .o_count (w_pop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_pixel_sum <= '0;
      else if (w_start || w_abort) r_pixel_sum <= '0;
      else if (w_accept)          r_pixel_sum <= r_pixel_sum + {5'd0, w_pop};
   end
   assign pixel_sum = r_pixel_sum;
`else
   assign pixel_sum = 8'd0;
`endif

   assign image_data  = r_image_data;
   assign chunk_idx   = r_chunk_idx;
   assign overrun     = r_overrun;
   assign busy        = (r_state == LD_LOAD);
   assign image_ready = (r_state == LD_READY);
endmodule
